// File: rtl/sr_cmd_arbiter_pkg.sv
// Shared types and defaults for the SR latch command arbiter.
package sr_ctrl_pkg;

  // Controller sequencing states
  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    DRIVE,
    GAP,
    CHECK
  } sr_state_t;

  localparam int N_REQ_DEF     = 4;
  localparam int PULSE_CYC_DEF = 2;
  localparam int GAP_CYC_DEF   = 1;

  // Larger of two integers, used to size the shared phase counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sr_cmd_arbiter_if.sv
// Requester, latch-pin and status bundle between the arbiter and its users.
interface sr_cmd_arbiter_if import sr_ctrl_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF
);
  logic [N_REQ-1:0] req_set;
  logic [N_REQ-1:0] req_clr;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] conflict;
  logic             busy;
  logic             latch_s;
  logic             latch_r;
  logic             latch_en;
  logic             latch_clr;
  logic             q_fb;
  logic             q_exp;
  logic             mismatch;

  // Requesters plus the latch feedback path
  modport master (
    output req_set, req_clr, q_fb,
    input  grant, conflict, busy, latch_s, latch_r, latch_en, latch_clr,
    input  q_exp, mismatch
  );

  // The arbiter itself
  modport slave (
    input  req_set, req_clr, q_fb,
    output grant, conflict, busy, latch_s, latch_r, latch_en, latch_clr,
    output q_exp, mismatch
  );
endinterface

// File: rtl/sr_cmd_arbiter_rr_arbiter_n.sv
// Combinational round-robin pick: first valid index at or above ptr, wrapping.
module rr_arbiter_n import sr_ctrl_pkg::*; #(
  parameter int N  = N_REQ_DEF,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          any_valid
);

  logic [PW:0] pos;

  // Walk the ring starting at ptr; the first valid index found wins
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    pos       = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
      if (!any_valid && valid[pos[PW-1:0]]) begin
        winner[pos[PW-1:0]] = 1'b1;
        any_valid           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_cmd_arbiter.sv
// Shares one SR latch between N_REQ requesters: round-robin arbitration of
// set/clear requests, pulse/gap sequencing of the latch pins and a post-command
// readback check with a sticky mismatch flag.
module sr_cmd_arbiter import sr_ctrl_pkg::*; #(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int PULSE_CYC = PULSE_CYC_DEF,
  parameter int GAP_CYC   = GAP_CYC_DEF
) (
  input logic          clk,
  input logic          rst,
  sr_cmd_arbiter_if.slave bus
);

  localparam int PW    = $clog2(N_REQ);
  localparam int CNT_W = $clog2(max_int(PULSE_CYC, GAP_CYC) + 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);

  sr_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    rr_ptr;

  logic [N_REQ-1:0] valid;
  logic [N_REQ-1:0] winner;
  logic             any_valid;
  logic             win_set;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    next_ptr;

  // Index of the single set bit of a one-hot vector
  function automatic logic [PW-1:0] onehot_idx(input logic [N_REQ-1:0] oh);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = PW'(i);
    end
    return idx;
  endfunction

  // A requester asserting both set and clear is not a valid command
  assign valid    = bus.req_set ^ bus.req_clr;
  assign win_set  = |(winner & bus.req_set);
  assign win_idx  = onehot_idx(winner);
  assign next_ptr = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);

  rr_arbiter_n #(
    .N  (N_REQ),
    .PW (PW)
  ) u_rr (
    .valid     (valid),
    .ptr       (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // Controller FSM; every output is registered alongside the state it belongs to
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= CLEAR;
      cnt           <= '0;
      rr_ptr        <= '0;
      bus.grant     <= '0;
      bus.conflict  <= '0;
      bus.busy      <= 1'b1;
      bus.latch_s   <= 1'b0;
      bus.latch_r   <= 1'b0;
      bus.latch_en  <= 1'b1;
      bus.latch_clr <= 1'b1;
      bus.q_exp     <= 1'b0;
      bus.mismatch  <= 1'b0;
    end else begin
      bus.grant    <= '0;
      bus.conflict <= '0;
      case (state)
        CLEAR: begin
          state         <= GAP;
          cnt           <= GAP_LD;
          bus.latch_en  <= 1'b0;
          bus.latch_clr <= 1'b0;
          bus.latch_s   <= 1'b0;
          bus.latch_r   <= 1'b0;
        end
        IDLE: begin
          bus.conflict <= bus.req_set & bus.req_clr;
          if (any_valid) begin
            state        <= DRIVE;
            cnt          <= PULSE_LD;
            rr_ptr       <= next_ptr;
            bus.grant    <= winner;
            bus.busy     <= 1'b1;
            bus.q_exp    <= win_set;
            bus.latch_en <= 1'b1;
            bus.latch_s  <= win_set;
            bus.latch_r  <= ~win_set;
          end
        end
        DRIVE: begin
          if (cnt == '0) begin
            state        <= GAP;
            cnt          <= GAP_LD;
            bus.latch_en <= 1'b0;
            bus.latch_s  <= 1'b0;
            bus.latch_r  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state <= CHECK;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        CHECK: begin
          if (bus.q_fb != bus.q_exp) bus.mismatch <= 1'b1;
          state    <= IDLE;
          cnt      <= '0;
          bus.busy <= 1'b0;
        end
        default: begin
          state         <= CLEAR;
          cnt           <= '0;
          bus.busy      <= 1'b1;
          bus.latch_en  <= 1'b1;
          bus.latch_clr <= 1'b1;
          bus.latch_s   <= 1'b0;
          bus.latch_r   <= 1'b0;
        end
      endcase
    end
  end

  // The latch must never see s and r asserted together
  a_sr_exclusive: assert property (@(posedge clk) !(bus.latch_s && bus.latch_r));

endmodule
